// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and MEM/WB payload layout.
package pipe_pkg;

    localparam int unsigned CTRL_W  = 2;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned MEMWB_W = CTRL_W + RD_W + 2 * XLEN;

    // MEM/WB payload field offsets (LSB positions), ctrl in the top bits.
    localparam int unsigned RDATA_LSB = 0;
    localparam int unsigned ALU_LSB   = RDATA_LSB + XLEN;
    localparam int unsigned RD_LSB    = ALU_LSB + XLEN;
    localparam int unsigned CTRL_LSB  = RD_LSB + RD_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   read_data;
    } memwb_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer used at each pipeline boundary; all handshake outputs are registered.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 135,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic [1:0]           occupancy_q, occupancy_d;
    logic                 accept;
    logic                 pop;
    logic                 stall;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;
    assign stall  = out_valid_q && !out_ready;

    // Next-state and payload steering; flush overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occupancy_d = 2'd0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Registered handshake outputs follow the upcoming state.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
        case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_TWO:  occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State, payload and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall),
        .count(stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, skid, flush, reset and saturation.
module tb_pipe_skid_stage;

    localparam int unsigned PW = 135;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int n_cmp;
    int n_bad;

    pipe_skid_stage #(
        .PAYLOAD_W(PW),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    logic [PW-1:0] pa, pb, pc, pd, pe;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pa = {7'h55, 64'hAAAA_0000_0000_0001, 64'h1111_2222_3333_4444};
        pb = {7'h2A, 64'hBBBB_0000_0000_0002, 64'h5555_6666_7777_8888};
        pc = {7'h11, 64'hCCCC_0000_0000_0003, 64'h9999_AAAA_BBBB_CCCC};
        pd = 135'hD0D0;
        pe = 135'hE0E0;

        // Reset
        reset = 1'b1;
        drive(1'b1, pa, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_in_ready",  PW'(in_ready),  PW'(1));
        check("rst_occ",       PW'(occupancy), PW'(0));
        check("rst_stall",     PW'(stall_cnt), PW'(0));
        check("rst_out_data",  out_data,       PW'(0));

        // Streaming: payloads 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, PW'(i), 1'b1, 1'b0);
            tick();
            check("stream_valid", PW'(out_valid), PW'(1));
            check("stream_data",  out_data,       PW'(i));
            check("stream_occ",   PW'(occupancy), PW'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("stream_drain_valid", PW'(out_valid), PW'(0));
        check("stream_stall",       PW'(stall_cnt), PW'(0));

        // Skid: A loaded, B skids, C held off, then drain in order
        drive(1'b1, pa, 1'b0, 1'b0);
        tick();
        check("skid_a_occ",  PW'(occupancy), PW'(1));
        check("skid_a_data", out_data,       pa);
        drive(1'b1, pb, 1'b0, 1'b0);
        tick();
        check("skid_b_occ",   PW'(occupancy), PW'(2));
        check("skid_b_ready", PW'(in_ready),  PW'(0));
        check("skid_b_data",  out_data,       pa);
        check("skid_b_stall", PW'(stall_cnt), PW'(1));
        drive(1'b1, pc, 1'b0, 1'b0);
        tick();
        check("skid_c_occ",   PW'(occupancy), PW'(2));
        check("skid_c_data",  out_data,       pa);
        check("skid_c_stall", PW'(stall_cnt), PW'(2));
        drive(1'b1, pc, 1'b1, 1'b0);
        tick();
        check("drain_b_data",  out_data,       pb);
        check("drain_b_occ",   PW'(occupancy), PW'(1));
        check("drain_b_ready", PW'(in_ready),  PW'(1));
        drive(1'b1, pc, 1'b1, 1'b0);
        tick();
        check("drain_c_data", out_data,       pc);
        check("drain_c_occ",  PW'(occupancy), PW'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("drain_empty", PW'(out_valid), PW'(0));
        check("skid_stall",  PW'(stall_cnt), PW'(2));

        // Flush colliding with accept and pop while in TWO
        drive(1'b1, pa, 1'b0, 1'b0);
        tick();
        drive(1'b1, pb, 1'b0, 1'b0);
        tick();
        check("pre_flush_occ", PW'(occupancy), PW'(2));
        drive(1'b1, pd, 1'b1, 1'b1);
        tick();
        check("flush_occ",   PW'(occupancy), PW'(0));
        check("flush_valid", PW'(out_valid), PW'(0));
        check("flush_ready", PW'(in_ready),  PW'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("post_flush_valid", PW'(out_valid), PW'(0));
        check("flush_stall",      PW'(stall_cnt), PW'(3));

        // Reset mid-operation with occupancy 2 and stall_cnt 5
        drive(1'b1, pa, 1'b0, 1'b0);
        tick();
        drive(1'b1, pb, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("pre_rst_occ",   PW'(occupancy), PW'(2));
        check("pre_rst_stall", PW'(stall_cnt), PW'(5));
        reset = 1'b1;
        drive(1'b1, pe, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        check("mid_rst_valid", PW'(out_valid), PW'(0));
        check("mid_rst_ready", PW'(in_ready),  PW'(1));
        check("mid_rst_occ",   PW'(occupancy), PW'(0));
        check("mid_rst_stall", PW'(stall_cnt), PW'(0));
        check("mid_rst_data",  out_data,       PW'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("post_rst_valid", PW'(out_valid), PW'(0));

        // Saturation of the 3-bit stall counter
        drive(1'b1, pa, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) check("sat_stall_6", PW'(stall_cnt), PW'(6));
            if (i == 7) check("sat_stall_7", PW'(stall_cnt), PW'(7));
        end
        check("sat_stall_10", PW'(stall_cnt), PW'(7));
        check("sat_data",     out_data,       pa);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("sat_flush_occ",   PW'(occupancy), PW'(0));
        check("sat_flush_stall", PW'(stall_cnt), PW'(7));
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("sat_idle_stall", PW'(stall_cnt), PW'(7));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat_rst_stall", PW'(stall_cnt), PW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
